// File: rtl/shift_seq_arbiter.sv
// shift_seq_arbiter: two-requester round-robin arbiter driving a WIDTH-bit serial shift transfer
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   req[1:0]             per-requester transfer request (held until gnt)
//   req_dir[1:0]         per-requester direction, 1 = MSB first, 0 = LSB first
//   req_data0/1          parallel load words of requester 0/1
//   gnt[1:0]             one-hot accept pulse, asserted in the IDLE cycle that loads the word
//   ser_out, ser_in      serial data out/in, active only while shift_en
//   shift_en             high during the WIDTH shift cycles
//   busy                 high in every state except IDLE
//   owner                requester index of the current or last transfer
//   done[1:0]            one-hot completion pulse to the owner
//   rd_data              word captured at the end of the transfer, held until the next one
module shift_seq_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req,
    input  logic [1:0]       req_dir,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    output logic [1:0]       gnt,
    output logic             ser_out,
    input  logic             ser_in,
    output logic             shift_en,
    output logic             busy,
    output logic             owner,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] rd_data
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [CW-1:0]    cnt;
    logic             dir;
    logic             last;
    logic             win1;

    // last holds the previously granted requester; it resets to 1 so requester 0 wins the first tie
    assign win1     = req[1] & (~req[0] | ~last);
    // gnt is decoded combinationally so the accept lands in the same IDLE cycle as the load
    assign gnt      = (reset_n && state == IDLE) ? (win1 ? 2'b10 : {1'b0, req[0]}) : 2'b00;
    assign sreg_nxt = dir ? {sreg[WIDTH-2:0], ser_in} : {ser_in, sreg[WIDTH-1:1]};
    assign shift_en = state == SHIFT;
    assign ser_out  = shift_en & (dir ? sreg[WIDTH-1] : sreg[0]);
    assign busy     = state != IDLE;
    assign done     = (state == DONE) ? (owner ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            dir     <= 1'b0;
            last    <= 1'b1;
            owner   <= 1'b0;
            rd_data <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    state <= SHIFT;
                    sreg  <= win1 ? req_data1 : req_data0;
                    dir   <= win1 ? req_dir[1] : req_dir[0];
                    owner <= win1;
                    last  <= win1;
                    cnt   <= '0;
                end
                SHIFT: begin
                    sreg <= sreg_nxt;
                    cnt  <= cnt + CW'(1);
                    // capture the final shifted word so rd_data is already valid in the DONE cycle
                    if (cnt == CW'(WIDTH - 1)) begin
                        state   <= DONE;
                        rd_data <= sreg_nxt;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_seq_arbiter.sv
// tb_shift_seq_arbiter: self-checking bench for shift_seq_arbiter with a completion scoreboard
module tb_shift_seq_arbiter;
    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic [1:0]   req;
    logic [1:0]   req_dir;
    logic [W-1:0] req_data0;
    logic [W-1:0] req_data1;
    logic [1:0]   gnt;
    logic         ser_out;
    logic         ser_in;
    logic         shift_en;
    logic         busy;
    logic         owner;
    logic [1:0]   done;
    logic [W-1:0] rd_data;

    logic         loop;
    logic         ser_fix;
    int           checks;
    int           fails;
    logic [W:0]   sb[$];

    assign ser_in = loop ? ser_out : ser_fix;

    shift_seq_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_dir(req_dir),
        .req_data0(req_data0), .req_data1(req_data1), .gnt(gnt),
        .ser_out(ser_out), .ser_in(ser_in), .shift_en(shift_en), .busy(busy),
        .owner(owner), .done(done), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset_n = 1'b0;
        req = 2'b11;
        req_dir = 2'b11;
        req_data0 = 8'h3C;
        req_data1 = 8'hC3;
        loop = 1'b1;
        ser_fix = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({gnt, done, shift_en, ser_out, busy, owner, rd_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got gnt=%b done=%b sh=%b so=%b busy=%b own=%b rd=%h, wanted all 0",
                     gnt, done, shift_en, ser_out, busy, owner, rd_data);
        end
    endtask

    task automatic test_tie();
        logic [1:0] g_exp;
        logic [W:0] e;
        int ph;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            ph = k % 10;
            g_exp = (ph == 0) ? (((k / 10) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if (gnt !== g_exp) begin
                fails++;
                $display("FAIL tie_gnt k=%0d: got %b, wanted %b", k, gnt, g_exp);
            end
            if (ph == 0) sb.push_back({g_exp[1], g_exp[1] ? req_data1 : req_data0});
            checks++;
            if (busy !== (ph != 0)) begin
                fails++;
                $display("FAIL tie_busy k=%0d: got %b, wanted %b", k, busy, ph != 0);
            end
            if (ph == 9) begin
                e = sb.pop_front();
                checks++;
                if (done !== (e[W] ? 2'b10 : 2'b01) || rd_data !== e[W-1:0]) begin
                    fails++;
                    $display("FAIL tie_done k=%0d: got done=%b rd=%h, wanted done=%b rd=%h",
                             k, done, rd_data, e[W] ? 2'b10 : 2'b01, e[W-1:0]);
                end
            end else begin
                checks++;
                if (done !== 2'b00) begin
                    fails++;
                    $display("FAIL tie_nodone k=%0d: got %b, wanted 00", k, done);
                end
            end
        end
        @(negedge clk);
        req = 2'b00;
    endtask

    task automatic test_loopback();
        logic [W-1:0] bits;
        logic [W:0] e;
        bits = 8'hA5;
        @(negedge clk);
        loop = 1'b1;
        req_dir = 2'b01;
        req_data0 = 8'hA5;
        req = 2'b01;
        #1;
        checks++;
        if (gnt !== 2'b01) begin
            fails++;
            $display("FAIL loop_gnt: got %b, wanted 01", gnt);
        end
        sb.push_back({1'b0, 8'hA5});
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            req = 2'b00;
            #1;
            checks++;
            if (shift_en !== 1'b1 || ser_out !== bits[W-k] || gnt !== 2'b00) begin
                fails++;
                $display("FAIL loop_shift k=%0d: got sh=%b so=%b gnt=%b, wanted sh=1 so=%b gnt=00",
                         k, shift_en, ser_out, gnt, bits[W-k]);
            end
        end
        @(negedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (done !== 2'b01 || rd_data !== e[W-1:0] || owner !== e[W]) begin
            fails++;
            $display("FAIL loop_done: got done=%b rd=%h own=%b, wanted done=01 rd=%h own=%b",
                     done, rd_data, owner, e[W-1:0], e[W]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 2'b00 || busy !== 1'b0 || shift_en !== 1'b0 || ser_out !== 1'b0) begin
            fails++;
            $display("FAIL loop_idle: got done=%b busy=%b sh=%b so=%b, wanted all 0",
                     done, busy, shift_en, ser_out);
        end
    endtask

    task automatic test_lsb();
        logic [W:0] e;
        @(negedge clk);
        loop = 1'b0;
        ser_fix = 1'b1;
        req_dir = 2'b00;
        req_data1 = 8'h01;
        req = 2'b10;
        #1;
        checks++;
        if (gnt !== 2'b10) begin
            fails++;
            $display("FAIL lsb_gnt: got %b, wanted 10", gnt);
        end
        sb.push_back({1'b1, 8'hFF});
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            req = 2'b00;
            #1;
            checks++;
            if (shift_en !== 1'b1 || ser_out !== (k == 1)) begin
                fails++;
                $display("FAIL lsb_shift k=%0d: got sh=%b so=%b, wanted sh=1 so=%b",
                         k, shift_en, ser_out, k == 1);
            end
        end
        @(negedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (done !== 2'b10 || rd_data !== e[W-1:0] || owner !== e[W]) begin
            fails++;
            $display("FAIL lsb_done: got done=%b rd=%h own=%b, wanted done=10 rd=%h own=%b",
                     done, rd_data, owner, e[W-1:0], e[W]);
        end
        @(negedge clk);
        ser_fix = 1'b0;
    endtask

    task automatic test_ignore();
        logic [1:0] g_exp;
        logic [1:0] d_exp;
        logic [W:0] e;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                loop = 1'b1;
                req_dir = 2'b01;
                req_data0 = 8'h5A;
                req_data1 = 8'h96;
                req = 2'b01;
            end
            if (k == 1) req = 2'b00;
            if (k == 3) req = 2'b10;
            if (k == 11) req = 2'b00;
            #1;
            g_exp = (k == 0) ? 2'b01 : (k == 10) ? 2'b10 : 2'b00;
            checks++;
            if (gnt !== g_exp) begin
                fails++;
                $display("FAIL ignore_gnt k=%0d: got %b, wanted %b", k, gnt, g_exp);
            end
            if (k == 0) sb.push_back({1'b0, 8'h5A});
            if (k == 10) sb.push_back({1'b1, 8'h96});
            if (k == 9 || k == 19) begin
                e = sb.pop_front();
                d_exp = e[W] ? 2'b10 : 2'b01;
                checks++;
                if (done !== d_exp || rd_data !== e[W-1:0]) begin
                    fails++;
                    $display("FAIL ignore_done k=%0d: got done=%b rd=%h, wanted done=%b rd=%h",
                             k, done, rd_data, d_exp, e[W-1:0]);
                end
            end
        end
    endtask

    task automatic test_single_hold();
        logic [1:0] g_exp;
        logic [W:0] e;
        int ph;
        @(negedge clk);
        loop = 1'b1;
        req_dir = 2'b01;
        req_data0 = 8'hE7;
        req = 2'b01;
        #1;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            ph = k % 10;
            g_exp = (ph == 0) ? 2'b01 : 2'b00;
            checks++;
            if (gnt !== g_exp || busy !== (ph != 0)) begin
                fails++;
                $display("FAIL hold_gnt_busy k=%0d: got gnt=%b busy=%b, wanted gnt=%b busy=%b",
                         k, gnt, busy, g_exp, ph != 0);
            end
            if (ph == 0) sb.push_back({1'b0, 8'hE7});
            if (ph == 9) begin
                e = sb.pop_front();
                checks++;
                if (done !== 2'b01 || rd_data !== e[W-1:0]) begin
                    fails++;
                    $display("FAIL hold_done k=%0d: got done=%b rd=%h, wanted done=01 rd=%h",
                             k, done, rd_data, e[W-1:0]);
                end
            end
        end
        @(negedge clk);
        req = 2'b00;
    endtask

    task automatic test_midreset();
        logic [W:0] e;
        @(negedge clk);
        loop = 1'b1;
        req_dir = 2'b01;
        req_data0 = 8'hC3;
        req_data1 = 8'h69;
        req = 2'b01;
        #1;
        checks++;
        if (gnt !== 2'b01) begin
            fails++;
            $display("FAIL mid_gnt: got %b, wanted 01", gnt);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            req = 2'b00;
        end
        @(negedge clk);
        reset_n = 1'b0;
        req = 2'b10;
        #1;
        checks++;
        if ({gnt, done, shift_en, ser_out, busy, owner, rd_data} !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got gnt=%b done=%b sh=%b so=%b busy=%b own=%b rd=%h, wanted all 0",
                     gnt, done, shift_en, ser_out, busy, owner, rd_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 2'b00 || gnt !== 2'b00) begin
            fails++;
            $display("FAIL mid_reset_hold: got done=%b gnt=%b, wanted 00 00", done, gnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (gnt !== 2'b10) begin
            fails++;
            $display("FAIL mid_regrant: got %b, wanted 10", gnt);
        end
        sb.push_back({1'b1, 8'h69});
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            req = 2'b00;
            #1;
            if (k <= W) begin
                checks++;
                if (done !== 2'b00) begin
                    fails++;
                    $display("FAIL mid_nodone k=%0d: got %b, wanted 00", k, done);
                end
            end else begin
                e = sb.pop_front();
                checks++;
                if (done !== 2'b10 || rd_data !== e[W-1:0] || owner !== e[W]) begin
                    fails++;
                    $display("FAIL mid_done: got done=%b rd=%h own=%b, wanted done=10 rd=%h own=%b",
                             done, rd_data, owner, e[W-1:0], e[W]);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        fails = 0;
        test_reset();
        test_tie();
        test_loopback();
        test_lsb();
        test_ignore();
        test_single_hold();
        test_midreset();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_empty: got %0d pending, wanted 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
